// File: rtl/varredura_display.sv
`default_nettype none
// =============================================================================
// Module : varredura_display
// Time-multiplexed scan controller for common-anode 7-segment digits sharing
// one BCD decoder: per-slot blanking, double-buffered data, leading-zero blank.
// Revision: 1.0 - initial release
// =============================================================================
module varredura_display #(
    parameter int NUM_DIGITOS   = 4,
    parameter int DIV_VARREDURA = 1000,
    parameter int BLANK_CICLOS  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           habilita,
    input  logic                           carga,
    input  logic [4*NUM_DIGITOS-1:0]       dados,
    input  logic                           supr_zeros,
    output logic [3:0]                     codigo,
    output logic [NUM_DIGITOS-1:0]         anodo,
    output logic [$clog2(NUM_DIGITOS)-1:0] digito_atual,
    output logic                           quadro_fim
);

    localparam int CNT_W = $clog2(DIV_VARREDURA);
    localparam int IDX_W = $clog2(NUM_DIGITOS);

    typedef enum logic [1:0] {
        DESLIGADO = 2'd0,
        APAGANDO  = 2'd1,
        ACESO     = 2'd2
    } estado_t;

    estado_t                  estado;
    estado_t                  estado_prox;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_prox;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_prox;
    logic [4*NUM_DIGITOS-1:0] sombra;
    logic [4*NUM_DIGITOS-1:0] sombra_prox;
    logic [4*NUM_DIGITOS-1:0] ativo;
    logic [4*NUM_DIGITOS-1:0] ativo_prox;
    logic [3:0]               digitos [NUM_DIGITOS];
    logic [NUM_DIGITOS-1:0]   suprimido;
    logic [NUM_DIGITOS-1:0]   anodo_prox;
    logic [3:0]               codigo_prox;
    logic                     fim_prox;
    logic                     fronteira;
    logic                     todo_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= DESLIGADO;
            cnt        <= '0;
            idx        <= '0;
            sombra     <= '0;
            ativo      <= '0;
            anodo      <= '1;
            codigo     <= 4'hF;
            quadro_fim <= 1'b0;
        end else begin
            estado     <= estado_prox;
            cnt        <= cnt_prox;
            idx        <= idx_prox;
            sombra     <= sombra_prox;
            ativo      <= ativo_prox;
            anodo      <= anodo_prox;
            codigo     <= codigo_prox;
            quadro_fim <= fim_prox;
        end
    end

    assign digito_atual = idx;

    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        idx_prox    = idx;
        fim_prox    = 1'b0;
        case (estado)
            DESLIGADO: begin
                cnt_prox = '0;
                idx_prox = '0;
                if (habilita) estado_prox = APAGANDO;
            end
            APAGANDO: begin
                cnt_prox = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BLANK_CICLOS - 1)) estado_prox = ACESO;
            end
            ACESO: begin
                if (cnt == CNT_W'(DIV_VARREDURA - 1)) begin
                    estado_prox = APAGANDO;
                    cnt_prox    = '0;
                    if (idx == IDX_W'(NUM_DIGITOS - 1)) begin
                        idx_prox = '0;
                        fim_prox = 1'b1;
                    end else begin
                        idx_prox = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_prox = cnt + CNT_W'(1);
                end
            end
            default: begin
                estado_prox = DESLIGADO;
                cnt_prox    = '0;
                idx_prox    = '0;
            end
        endcase
        if (!habilita) begin
            estado_prox = DESLIGADO;
            cnt_prox    = '0;
            idx_prox    = '0;
            fim_prox    = 1'b0;
        end
    end

    // The first cycle of every idx-0 slot is the only point the active bank may change.
    assign fronteira = (estado == APAGANDO) && (cnt == '0) && (idx == '0);

    always_comb begin
        sombra_prox = carga ? dados : sombra;
        ativo_prox  = fronteira ? sombra_prox : ativo;
    end

    always_comb begin
        todo_zero = 1'b1;
        suprimido = '0;
        for (int i = NUM_DIGITOS - 1; i >= 0; i--) begin
            digitos[i]   = ativo_prox[4*i +: 4];
            todo_zero    = todo_zero && (digitos[i] == 4'h0);
            suprimido[i] = supr_zeros && todo_zero && (i != 0);
        end
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        anodo_prox  = '1;
        codigo_prox = 4'hF;
        if (estado_prox == ACESO) begin
            anodo_prox[idx_prox] = 1'b0;
            codigo_prox          = suprimido[idx_prox] ? 4'hF : digitos[idx_prox];
        end
    end

endmodule
`default_nettype wire
